// File: rtl/axis_ring_inject_arbiter.sv
// Packet-level round-robin arbiter sharing one ring injection port between
// NUM_REQUESTERS AXI-Stream masters, with a registered output slice.
module axis_ring_inject_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int TDATA_WIDTH    = 512,
    parameter int TID_WIDTH      = 2,
    parameter int TDEST_WIDTH    = 4,
    localparam int SRC_WIDTH     = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_REQUESTERS-1:0]                   in_tvalid,
    output logic [NUM_REQUESTERS-1:0]                   in_tready,
    input  logic [NUM_REQUESTERS-1:0][TDATA_WIDTH-1:0]  in_tdata,
    input  logic [NUM_REQUESTERS-1:0]                   in_tlast,
    input  logic [NUM_REQUESTERS-1:0][TID_WIDTH-1:0]    in_tid,
    input  logic [NUM_REQUESTERS-1:0][TDEST_WIDTH-1:0]  in_tdest,
    output logic                                        out_tvalid,
    input  logic                                        out_tready,
    output logic [TDATA_WIDTH-1:0]                      out_tdata,
    output logic                                        out_tlast,
    output logic [TID_WIDTH-1:0]                        out_tid,
    output logic [TDEST_WIDTH-1:0]                      out_tdest,
    output logic [SRC_WIDTH-1:0]                        out_src,
    output logic                                        busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state, state_nxt;
    logic [SRC_WIDTH-1:0] rr_ptr, rr_nxt;
    logic [SRC_WIDTH-1:0] grant, grant_nxt;
    logic [SRC_WIDTH-1:0] pick;
    logic                 any_req;
    logic                 slot_rdy;
    logic                 accept;

    function automatic logic [SRC_WIDTH-1:0] wrap_add(input logic [SRC_WIDTH-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_REQUESTERS) s = s - NUM_REQUESTERS;
        return SRC_WIDTH'(s);
    endfunction

    assign slot_rdy = !out_tvalid || out_tready;
    assign accept   = (state == LOCKED) && in_tvalid[grant] && slot_rdy;
    assign busy     = (state == LOCKED);

    // Walk offsets from the far end so the lowest offset from rr_ptr wins.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            if (in_tvalid[wrap_add(rr_ptr, k)]) begin
                pick    = wrap_add(rr_ptr, k);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant;
        in_tready = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = pick;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                in_tready[grant] = slot_rdy;
                if (accept && in_tlast[grant]) begin
                    rr_nxt    = wrap_add(grant, 1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            grant  <= grant_nxt;
        end
    end

    // Output slice: a load wins over a drain, fields only move on a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            out_tdata  <= '0;
            out_tid    <= '0;
            out_tdest  <= '0;
            out_src    <= '0;
        end else if (accept) begin
            out_tvalid <= 1'b1;
            out_tlast  <= in_tlast[grant];
            out_tdata  <= in_tdata[grant];
            out_tid    <= in_tid[grant];
            out_tdest  <= in_tdest[grant];
            out_src    <= grant;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

endmodule
